// File: rtl/lector_adc_temp_pkg.sv
// Shared types and widths for the LM35 / ADC0831 temperature reader.
package lector_adc_temp_pkg;

  localparam int unsigned ADC_W    = 8;
  localparam int unsigned TEMP_W   = 5;
  localparam int unsigned N_PULSES = 9;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StSckLo = 3'd2,
    StSckHi = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/temporizador_muestreo.sv
// Conversion interval timer: emits a one-cycle start after SAMPLE_PERIOD idle cycles.
module temporizador_muestreo #(
  parameter int unsigned SAMPLE_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic start
);

  localparam int unsigned CntW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CntW-1:0] cnt_q;
  logic            start_q;

  // Counter only advances while the reader is idle, so the interval restarts after each conversion.
  always_ff @(posedge clk) begin
    if (reset || clear || !run) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else if (cnt_q == CntW'(SAMPLE_PERIOD - 1)) begin
      cnt_q   <= '0;
      start_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      start_q <= 1'b0;
    end
  end

  assign start = start_q;

endmodule

// File: rtl/lector_adc_temp.sv
// Periodic ADC0831 reader: bit-bangs CS/SCLK, shifts in 8 bits, saturates to 0..31 degC.
module lector_adc_temp
  import lector_adc_temp_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 5_000_000,
  parameter int unsigned TEMP_MAX      = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              adc_dout,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic              temp_sat,
  output logic              busy
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(N_PULSES);
  localparam logic [BitW-1:0] LastBit = BitW'(N_PULSES - 1);

  state_e             state_q, state_d;
  logic [DivW-1:0]    div_q;
  logic [BitW-1:0]    bit_q;
  logic [ADC_W-1:0]   shift_q;
  logic               half_done, start, raw_sat;
  logic               cs_n_d, sclk_d, busy_d;

  temporizador_muestreo #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(~en),
    .run  (state_q == StIdle),
    .start(start)
  );

  assign half_done = (div_q == DivW'(CLK_DIV - 1));
  assign raw_sat   = (shift_q > ADC_W'(TEMP_MAX));

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start)     state_d = StSetup;
      StSetup: if (half_done) state_d = StSckLo;
      StSckLo: if (half_done) state_d = StSckHi;
      StSckHi: if (half_done) state_d = (bit_q == LastBit) ? StDone : StSckLo;
      StDone:                 state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_n_d = 1'b0;
    sclk_d = 1'b0;
    busy_d = 1'b1;
    case (state_d)
      StIdle: begin
        cs_n_d = 1'b1;
        busy_d = 1'b0;
      end
      StDone:  cs_n_d = 1'b1;
      StSckHi: sclk_d = 1'b1;
      default: ;
    endcase
  end

  // Data is captured on the edge that raises SCLK; pulse 0 is the ADC's null bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if (state_q == StIdle || state_q == StDone || half_done) div_q <= '0;
      else                                                      div_q <= div_q + 1'b1;
      if (state_q == StIdle) begin
        bit_q <= '0;
      end else if (state_q == StSckHi && half_done && bit_q != LastBit) begin
        bit_q <= bit_q + 1'b1;
      end
      if (state_q == StSckLo && half_done && bit_q != '0) begin
        shift_q <= {shift_q[ADC_W-2:0], adc_dout};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b0;
      busy       <= 1'b0;
      temp       <= '0;
      temp_valid <= 1'b0;
      temp_sat   <= 1'b0;
    end else begin
      adc_cs_n   <= cs_n_d;
      adc_sclk   <= sclk_d;
      busy       <= busy_d;
      temp_valid <= (state_q == StDone);
      if (state_q == StDone) begin
        temp     <= raw_sat ? TEMP_W'(TEMP_MAX) : shift_q[TEMP_W-1:0];
        temp_sat <= raw_sat;
      end
    end
  end

endmodule

// File: tb/tb_lector_adc_temp.sv
// Bench for lector_adc_temp with a behavioural ADC0831 that shifts a code out on SCLK falls.
module tb_lector_adc_temp;

  localparam int unsigned CLK_DIV       = 2;
  localparam int unsigned SAMPLE_PERIOD = 100;
  localparam int CONV_LAT = 19 * CLK_DIV + 1;
  localparam int SPACING  = SAMPLE_PERIOD + 19 * CLK_DIV + 2;
  localparam int LIMIT    = 2 * SAMPLE_PERIOD + 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       adc_dout = 1'bz;
  logic       adc_cs_n, adc_sclk, temp_valid, temp_sat, busy;
  logic [4:0] temp;

  logic [7:0] adc_code = 8'h00;
  int         falls = 0;
  logic       cs_prev = 1'b1;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  lector_adc_temp #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .TEMP_MAX     (31)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .adc_dout  (adc_dout),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .temp      (temp),
    .temp_valid(temp_valid),
    .temp_sat  (temp_sat),
    .busy      (busy)
  );

  // ADC model: X during the null pulse, MSB..LSB after each SCLK fall, Z otherwise.
  always @(adc_cs_n or negedge adc_sclk) begin
    if (adc_cs_n !== 1'b0) begin
      falls    = 0;
      adc_dout = 1'bz;
    end else if (cs_prev !== 1'b0) begin
      falls    = 0;
      adc_dout = 1'bx;
    end else begin
      falls++;
      adc_dout = (falls <= 8) ? adc_code[8 - falls] : 1'bz;
    end
    cs_prev = adc_cs_n;
  end

  function automatic logic [4:0] model_temp(input logic [7:0] code);
    int c = int'(code);
    return 5'((c > 31) ? 31 : c);
  endfunction

  function automatic logic model_sat(input logic [7:0] code);
    return int'(code) > 31;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs_fall(output int n);
    n = 0;
    while (n < LIMIT) begin
      tick();
      n++;
      if (adc_cs_n === 1'b0) break;
    end
  endtask

  task automatic wait_rises(input int k, output bit ok);
    int   r = 0;
    logic prev = adc_sclk;
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      if (adc_sclk === 1'b1 && prev === 1'b0) r++;
      prev = adc_sclk;
      if (r == k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int lat, output int rises, output bit busy_ok);
    logic prev = adc_sclk;
    lat = 0; rises = 0; busy_ok = 1'b1;
    while (lat < 1000) begin
      tick();
      lat++;
      if (adc_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = adc_sclk;
      if (temp_valid === 1'b1) break;
      if (adc_cs_n === 1'b0 && busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({adc_cs_n, adc_sclk, temp, temp_valid, temp_sat, busy} !== 10'b10_00000_000) begin
        n_err++;
        $display("FAIL reset[%0d]: got cs_n=%b sclk=%b temp=%0d valid=%b sat=%b busy=%b, want 1 0 0 0 0 0",
                 i, adc_cs_n, adc_sclk, temp, temp_valid, temp_sat, busy);
      end
    end
    reset = 1'b0;
    en    = 1'b0;
    tick();
  endtask

  task automatic test_first_conversion();
    int n, lat, rises;
    bit bok;
    adc_code = 8'h19;
    en = 1'b1;
    tick();  // edge that first samples en
    wait_cs_fall(n);
    n_cmp++;
    if (n !== SAMPLE_PERIOD) begin
      n_err++; $display("FAIL first_start: cs_n fell after %0d cycles, want %0d", n, SAMPLE_PERIOD);
    end
    wait_valid(lat, rises, bok);
    n_cmp++;
    if (lat !== CONV_LAT) begin
      n_err++; $display("FAIL first_latency: got %0d, want %0d", lat, CONV_LAT);
    end
    n_cmp++;
    if (rises !== 9) begin
      n_err++; $display("FAIL first_rises: got %0d, want 9", rises);
    end
    n_cmp++;
    if (bok !== 1'b1) begin
      n_err++; $display("FAIL first_busy: busy dropped while cs_n low (got %b, want 1)", bok);
    end
    n_cmp++;
    if (temp !== model_temp(adc_code)) begin
      n_err++; $display("FAIL first_temp: got %0d, want %0d", temp, model_temp(adc_code));
    end
    n_cmp++;
    if (temp_sat !== model_sat(adc_code)) begin
      n_err++; $display("FAIL first_sat: got %b, want %b", temp_sat, model_sat(adc_code));
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    logic [7:0] codes [3] = '{8'h1F, 8'h20, 8'hC8};
    int n, lat, rises;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      adc_code = codes[i];
      en = 1'b1;
      tick();
      wait_cs_fall(n);
      n_cmp++;
      if (n !== SAMPLE_PERIOD) begin
        n_err++; $display("FAIL bnd_start[%0d]: got %0d, want %0d", i, n, SAMPLE_PERIOD);
      end
      wait_valid(lat, rises, bok);
      n_cmp++;
      if (temp !== model_temp(adc_code) || temp_sat !== model_sat(adc_code)) begin
        n_err++;
        $display("FAIL bnd_code_%h: got temp=%0d sat=%b, want temp=%0d sat=%b", adc_code, temp,
                 temp_sat, model_temp(adc_code), model_sat(adc_code));
      end
      en = 1'b0;
      tick();
    end
  endtask

  task automatic test_en_drop();
    int n, lat, rises, stray;
    bit bok, ok;
    adc_code = 8'($urandom_range(1, 255));
    en = 1'b1;
    tick();
    wait_cs_fall(n);
    wait_rises(5, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL drop_pulses: got ok=%b, want 1", ok);
    end
    en = 1'b0;
    wait_valid(lat, rises, bok);
    n_cmp++;
    if (temp !== model_temp(adc_code) || temp_sat !== model_sat(adc_code)) begin
      n_err++;
      $display("FAIL drop_result: code %h got temp=%0d sat=%b, want temp=%0d sat=%b", adc_code,
               temp, temp_sat, model_temp(adc_code), model_sat(adc_code));
    end
    stray = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (adc_cs_n !== 1'b1) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_err++; $display("FAIL drop_idle: cs_n low for %0d cycles, want 0", stray);
    end
  endtask

  task automatic test_reset_mid();
    int n, lat, rises;
    bit bok, ok;
    adc_code = 8'($urandom_range(0, 255));
    en = 1'b1;
    tick();
    wait_cs_fall(n);
    wait_rises(6, ok);
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({adc_cs_n, adc_sclk, temp, temp_valid, temp_sat, busy} !== 10'b10_00000_000) begin
      n_err++;
      $display("FAIL mid_reset: got cs_n=%b sclk=%b temp=%0d valid=%b sat=%b busy=%b, want 1 0 0 0 0 0",
               adc_cs_n, adc_sclk, temp, temp_valid, temp_sat, busy);
    end
    reset = 1'b0;
    adc_code = 8'($urandom_range(0, 255));
    tick();
    wait_cs_fall(n);
    n_cmp++;
    if (n !== SAMPLE_PERIOD) begin
      n_err++; $display("FAIL mid_restart: got %0d, want %0d", n, SAMPLE_PERIOD);
    end
    wait_valid(lat, rises, bok);
    n_cmp++;
    if (rises !== 9 || lat !== CONV_LAT) begin
      n_err++; $display("FAIL mid_conv: got rises=%0d lat=%0d, want 9 %0d", rises, lat, CONV_LAT);
    end
    n_cmp++;
    if (temp !== model_temp(adc_code) || temp_sat !== model_sat(adc_code)) begin
      n_err++;
      $display("FAIL mid_result: code %h got temp=%0d sat=%b, want temp=%0d sat=%b", adc_code,
               temp, temp_sat, model_temp(adc_code), model_sat(adc_code));
    end
  endtask

  // en stays high from the previous test; each loop starts on a valid strobe.
  task automatic test_back_to_back();
    int lat, rises;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      adc_code = (i == 0) ? 8'h12 : 8'($urandom_range(0, 255));
      wait_valid(lat, rises, bok);
      n_cmp++;
      if (lat !== SPACING) begin
        n_err++; $display("FAIL b2b_spacing[%0d]: got %0d, want %0d", i, lat, SPACING);
      end
      n_cmp++;
      if (temp !== model_temp(adc_code)) begin
        n_err++; $display("FAIL b2b_temp[%0d]: code %h got %0d, want %0d", i, adc_code, temp,
                          model_temp(adc_code));
      end
      n_cmp++;
      if (temp_sat !== model_sat(adc_code)) begin
        n_err++; $display("FAIL b2b_sat[%0d]: code %h got %b, want %b", i, adc_code, temp_sat,
                          model_sat(adc_code));
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_conversion();
    test_boundary();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
